exe_stage_md: RTL and testbench
===============================

Name: exe_stage_md

Overview:
- Execute stage; sits directly upstream of the data-memory stage and drives its inputs through the EX/MEM pipeline register.
- Computes ALU results and load/store addresses in a single cycle.
- Contains an iterative 32-cycle multiply/divide unit with HI/LO registers.
- Raises STALL when an instruction needs HI/LO while the unit is busy.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
DIV_ZERO_LO, 32'hFFFF_FFFF, value written to LO on divide-by-zero.

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
valid1  in  1  incoming ID/EX slot holds a real instruction
Instr1  in  32  instruction word
ALU_control1  in  6  operation code
operandA1  in  32  rs value
operandB1  in  32  rt value or immediate
readDataB1  in  32  rt value, used as store data
writeRegister1  in  5  destination register
do_writeback1, MemRead1, MemWrite1, MemtoReg1  in  1 each  control bits
writeRegister1_WB  in  5  WB-stage destination (bypass)
writeData1_WB  in  32  WB-stage result (bypass)
do_writeback1_WB  in  1  WB-stage write enable (bypass)
STALL  out  1  hold the ID/EX register and the front end
Instr_OUT_PR  out  32  registered instruction
aluResult1_PR  out  32  registered ALU result or address
readDataB1_PR  out  32  registered store data
writeRegister1_PR  out  5  registered destination
do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR  out  1 each  registered control bits
md_busy  out  1  multiply/divide unit busy

Behaviour:
- Reset is asynchronous and active-low. All _PR outputs, HI, LO, the cycle counter and the FSM state go to 0 / IDLE.
- Reset mid-operation aborts the operation. HI and LO read as 0 afterwards.
- ALU codes (package constants):
  - SUB 100010; AND 100100; OR 100101; XOR 100110; NOR 100111.
  - SLT 111010 (signed compare); SLTU 111011 (unsigned compare). Both produce 0 or 1.
  - SLL 000000 and SRL 000010: shift operandB1 by Instr1[10:6].
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - Any other code: A+B, modulo 2^32, no overflow trap. This covers address generation for every load and store.
- ALU latency is 1 cycle. The result and all control bits appear at the _PR outputs after the next rising edge.
- Multiply/divide FSM states: IDLE, MUL, DIV.
  - A valid MULT/MULTU/DIV/DIVU accepted in IDLE captures operand magnitudes and sign flags, loads count=32, and moves to MUL or DIV.
  - MUL runs a shift-add step per cycle; DIV runs a restoring step per cycle.
  - When count reaches 0, HI/LO are written on that edge and the FSM returns to IDLE.
  - HI/LO are therefore valid 32 edges after the accepting edge.
- Result conventions:
  - Signed results: negate the product, or the quotient when the operand signs differ; the remainder takes the dividend's sign.
  - MULT: HI = upper 32 bits of the product, LO = lower 32 bits.
  - DIV: LO = quotient, HI = remainder.
  - Divide by zero: HI = dividend, LO = DIV_ZERO_LO.
- A multiply/divide instruction itself retires into EX/MEM with do_writeback1_PR=0 and aluResult1_PR=0.
- MTHI/MTLO in IDLE write HI/LO at the edge. MFHI/MFLO place HI/LO on aluResult1_PR.
- STALL (combinational) = valid1 & md_busy & (ALU_control1 is a MUL/DIV/MF*/MT* code).
  - While STALL=1, EX/MEM loads a bubble: all control bits 0 and Instr_OUT_PR=0. Data fields are don't-care.
  - Non-HI/LO instructions never stall and flow while the unit is busy.
- valid1=0 loads a bubble and starts no operation.

Optional Feature:
EXE_WB_BYPASS_EN
- Defined:
  - If do_writeback1_WB=1, writeRegister1_WB != 0 and writeRegister1_WB == Instr1[25:21], operandA is replaced by writeData1_WB.
  - The same check against Instr1[20:16] replaces readDataB1, and also operandB1 for R-type (Instr1[31:26]==0).
- Not defined: the three bypass ports are ignored and operands pass through unchanged.

Decomposition:
- Shared package exe_pkg: 6-bit ALU code constants, the FSM state enum, and the MD_ITER=32 constant.
- One natural sub-module: exe_muldiv_unit, containing the FSM, counter, iterative datapath and HI/LO.
- The top level holds the ALU, the bypass muxes, STALL generation and the EX/MEM register.

Test Plan:
- ADD-default code 101101 with A=0x1000, B=0x3 -> next edge aluResult1_PR=0x1003, MemRead1_PR follows MemRead1.
- SLT A=0xFFFFFFFF, B=1 -> aluResult1_PR=1. Same operands with SLTU -> aluResult1_PR=0.
- MULT A=-3, B=7, then MFLO presented the next cycle:
  - STALL=1 for 32 cycles and bubbles enter EX/MEM.
  - Then aluResult1_PR=0xFFFFFFEB; MFHI gives 0xFFFFFFFF.
- DIVU A=100, B=0 -> after 32 cycles LO=0xFFFFFFFF, HI=100. DIV A=-7, B=2 -> LO=-3, HI=-1.
- DIV in flight with an independent ADD and a SW following -> neither stalls, both appear at the _PR outputs on consecutive edges.
- RESET pulled low at cycle 10 of a MULT -> md_busy=0 and all _PR outputs=0 immediately. MFHI after release returns 0. With EXE_WB_BYPASS_EN, a WB write to r5=0xAB with Instr1 rs=r5 -> operandA uses 0xAB.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, the
// multiply/divide FSM state type and the iteration count.
package exe_pkg;

  localparam logic [5:0] ALU_SLL   = 6'b000000;
  localparam logic [5:0] ALU_SRL   = 6'b000010;
  localparam logic [5:0] ALU_MFHI  = 6'b010000;
  localparam logic [5:0] ALU_MTHI  = 6'b010001;
  localparam logic [5:0] ALU_MFLO  = 6'b010010;
  localparam logic [5:0] ALU_MTLO  = 6'b010011;
  localparam logic [5:0] ALU_MULT  = 6'b011000;
  localparam logic [5:0] ALU_MULTU = 6'b011001;
  localparam logic [5:0] ALU_DIV   = 6'b011010;
  localparam logic [5:0] ALU_DIVU  = 6'b011011;
  localparam logic [5:0] ALU_SUB   = 6'b100010;
  localparam logic [5:0] ALU_AND   = 6'b100100;
  localparam logic [5:0] ALU_OR    = 6'b100101;
  localparam logic [5:0] ALU_XOR   = 6'b100110;
  localparam logic [5:0] ALU_NOR   = 6'b100111;
  localparam logic [5:0] ALU_SLT   = 6'b111010;
  localparam logic [5:0] ALU_SLTU  = 6'b111011;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] code);
    return (code == ALU_MULT) || (code == ALU_MULTU) ||
           (code == ALU_DIV)  || (code == ALU_DIVU);
  endfunction

  function automatic logic is_hilo(input logic [5:0] code);
    return is_muldiv(code) ||
           (code == ALU_MFHI) || (code == ALU_MTHI) ||
           (code == ALU_MFLO) || (code == ALU_MTLO);
  endfunction

endpackage

// File: rtl/exe_muldiv_unit.sv
// Iterative 32-step multiply (shift-add) / divide (restoring) unit with the
// HI/LO register pair. The FSM state is exported on 'state' for debug.
module exe_muldiv_unit
  import exe_pkg::*;
#(
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output md_state_t   state
);

  md_state_t   state_q, state_d;
  logic [5:0]  count_q;
  logic [63:0] acc_q;
  logic [31:0] dvs_q;
  logic        neg_a_q, neg_b_q, div0_q;
  logic [31:0] hi_q, lo_q;

  logic        op_signed, op_mul, na, nb, last;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    op_signed = (op == ALU_MULT) || (op == ALU_DIV);
    op_mul    = (op == ALU_MULT) || (op == ALU_MULTU);
    na        = op_signed & a[31];
    nb        = op_signed & b[31];
    a_mag     = na ? -a : a;
    b_mag     = nb ? -b : b;
    last      = (count_q == 6'd1);
    // Multiply: acc = {partial product, remaining multiplier bits}.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    // Divide: acc = {partial remainder, dividend bits becoming quotient}.
    div_shift = {acc_q[63:32], acc_q[31]};
    div_diff  = div_shift - {1'b0, dvs_q};
    div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                             : {div_diff[31:0],  acc_q[30:0], 1'b1};
    prod_fix  = (neg_a_q ^ neg_b_q) ? -mul_next : mul_next;
    quot_fix  = (neg_a_q ^ neg_b_q) ? -div_next[31:0] : div_next[31:0];
    rem_fix   = neg_a_q ? -div_next[63:32] : div_next[63:32];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (start) state_d = op_mul ? MD_MUL : MD_DIV;
      MD_MUL:  if (last) state_d = MD_IDLE;
      MD_DIV:  if (last) state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            count_q <= 6'(MD_ITER);
            neg_a_q <= na;
            neg_b_q <= nb;
            if (op_mul) begin
              acc_q  <= {32'd0, b_mag};
              dvs_q  <= a_mag;
              div0_q <= 1'b0;
            end else begin
              acc_q  <= {32'd0, a_mag};
              div0_q <= (b == 32'd0);
              // A zero divisor never feeds a meaningful result, so the slot
              // keeps the raw dividend for the HI writeback instead.
              dvs_q  <= (b == 32'd0) ? a : b_mag;
            end
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        MD_MUL: begin
          acc_q   <= mul_next;
          count_q <= count_q - 6'd1;
          if (last) {hi_q, lo_q} <= prod_fix;
        end
        MD_DIV: begin
          acc_q   <= div_next;
          count_q <= count_q - 6'd1;
          if (last) begin
            hi_q <= div0_q ? dvs_q : rem_fix;
            lo_q <= div0_q ? DIV_ZERO_LO : quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != MD_IDLE);
  assign state = state_q;

endmodule

// File: rtl/exe_stage_md.sv
// Execute stage: single-cycle ALU, HI/LO stall logic and the EX/MEM register.
// Optional WB-to-EX operand bypass is compiled in with EXE_WB_BYPASS_EN.
module exe_stage_md
  import exe_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              valid1,
  input  logic [31:0]       Instr1,
  input  logic [5:0]        ALU_control1,
  input  logic [DATA_W-1:0] operandA1,
  input  logic [DATA_W-1:0] operandB1,
  input  logic [DATA_W-1:0] readDataB1,
  input  logic [4:0]        writeRegister1,
  input  logic              do_writeback1,
  input  logic              MemRead1,
  input  logic              MemWrite1,
  input  logic              MemtoReg1,
  input  logic [4:0]        writeRegister1_WB,
  input  logic [DATA_W-1:0] writeData1_WB,
  input  logic              do_writeback1_WB,
  output logic              STALL,
  output logic [31:0]       Instr_OUT_PR,
  output logic [DATA_W-1:0] aluResult1_PR,
  output logic [DATA_W-1:0] readDataB1_PR,
  output logic [4:0]        writeRegister1_PR,
  output logic              do_writeback1_PR,
  output logic              MemRead1_PR,
  output logic              MemWrite1_PR,
  output logic              MemtoReg1_PR,
  output logic              md_busy
);

  // Handshake: valid1 qualifies the ID/EX slot and STALL is its not-ready;
  // the slot is consumed on a rising edge only when valid1 & !STALL, else
  // EX/MEM loads a bubble.
  logic [DATA_W-1:0] op_a, op_b, store_data, alu_result, hi, lo;
  logic              bubble, md_start, hilo_ok;
  md_state_t         md_state_unused;

`ifdef EXE_WB_BYPASS_EN
  logic hit_rs, hit_rt;
  always_comb begin
    hit_rs     = do_writeback1_WB && (writeRegister1_WB != 5'd0) &&
                 (writeRegister1_WB == Instr1[25:21]);
    hit_rt     = do_writeback1_WB && (writeRegister1_WB != 5'd0) &&
                 (writeRegister1_WB == Instr1[20:16]);
    op_a       = hit_rs ? writeData1_WB : operandA1;
    store_data = hit_rt ? writeData1_WB : readDataB1;
    op_b       = (hit_rt && (Instr1[31:26] == 6'd0)) ? writeData1_WB : operandB1;
  end
`else
  logic bypass_unused;
  assign bypass_unused = ^{writeRegister1_WB, writeData1_WB, do_writeback1_WB};
  always_comb begin
    op_a       = operandA1;
    op_b       = operandB1;
    store_data = readDataB1;
  end
`endif

  assign STALL    = valid1 & md_busy & is_hilo(ALU_control1);
  assign bubble   = !valid1 || STALL;
  assign hilo_ok  = valid1 & !md_busy;
  assign md_start = hilo_ok & is_muldiv(ALU_control1);

  always_comb begin
    alu_result = op_a + op_b;
    case (ALU_control1)
      ALU_SUB:   alu_result = op_a - op_b;
      ALU_AND:   alu_result = op_a & op_b;
      ALU_OR:    alu_result = op_a | op_b;
      ALU_XOR:   alu_result = op_a ^ op_b;
      ALU_NOR:   alu_result = ~(op_a | op_b);
      ALU_SLT:   alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:   alu_result = op_b << Instr1[10:6];
      ALU_SRL:   alu_result = op_b >> Instr1[10:6];
      ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU: alu_result = '0;
      ALU_MFHI:  alu_result = hi;
      ALU_MFLO:  alu_result = lo;
      ALU_MTHI, ALU_MTLO: alu_result = op_a;
      default:   ;
    endcase
  end

  exe_muldiv_unit #(
    .DIV_ZERO_LO (DIV_ZERO_LO)
  ) u_muldiv (
    .clk   (CLK),
    .rst_n (RESET),
    .start (md_start),
    .op    (ALU_control1),
    .a     (op_a),
    .b     (op_b),
    .mthi  (hilo_ok & (ALU_control1 == ALU_MTHI)),
    .mtlo  (hilo_ok & (ALU_control1 == ALU_MTLO)),
    .wdata (op_a),
    .hi    (hi),
    .lo    (lo),
    .busy  (md_busy),
    .state (md_state_unused)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr_OUT_PR      <= '0;
      aluResult1_PR     <= '0;
      readDataB1_PR     <= '0;
      writeRegister1_PR <= '0;
      do_writeback1_PR  <= 1'b0;
      MemRead1_PR       <= 1'b0;
      MemWrite1_PR      <= 1'b0;
      MemtoReg1_PR      <= 1'b0;
    end else if (bubble) begin
      Instr_OUT_PR      <= '0;
      aluResult1_PR     <= '0;
      readDataB1_PR     <= '0;
      writeRegister1_PR <= '0;
      do_writeback1_PR  <= 1'b0;
      MemRead1_PR       <= 1'b0;
      MemWrite1_PR      <= 1'b0;
      MemtoReg1_PR      <= 1'b0;
    end else begin
      Instr_OUT_PR      <= Instr1;
      aluResult1_PR     <= alu_result;
      readDataB1_PR     <= store_data;
      writeRegister1_PR <= writeRegister1;
      do_writeback1_PR  <= do_writeback1 & !is_muldiv(ALU_control1);
      MemRead1_PR       <= MemRead1;
      MemWrite1_PR      <= MemWrite1;
      MemtoReg1_PR      <= MemtoReg1;
    end
  end

endmodule

// File: tb/tb_exe_stage_md.sv
// Scoreboard bench for exe_stage_md: directed vectors push expected EX/MEM
// contents, a monitor pops and compares after every rising edge.
module tb_exe_stage_md;
  import exe_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        valid1 = 1'b0;
  logic [31:0] Instr1 = '0;
  logic [5:0]  ALU_control1 = '0;
  logic [31:0] operandA1 = '0, operandB1 = '0, readDataB1 = '0;
  logic [4:0]  writeRegister1 = '0;
  logic        do_writeback1 = 1'b0, MemRead1 = 1'b0, MemWrite1 = 1'b0, MemtoReg1 = 1'b0;
  logic [4:0]  writeRegister1_WB = '0;
  logic [31:0] writeData1_WB = '0;
  logic        do_writeback1_WB = 1'b0;
  logic        STALL, md_busy;
  logic [31:0] Instr_OUT_PR, aluResult1_PR, readDataB1_PR;
  logic [4:0]  writeRegister1_PR;
  logic        do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR;

  exe_stage_md dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .valid1            (valid1),
    .Instr1            (Instr1),
    .ALU_control1      (ALU_control1),
    .operandA1         (operandA1),
    .operandB1         (operandB1),
    .readDataB1        (readDataB1),
    .writeRegister1    (writeRegister1),
    .do_writeback1     (do_writeback1),
    .MemRead1          (MemRead1),
    .MemWrite1         (MemWrite1),
    .MemtoReg1         (MemtoReg1),
    .writeRegister1_WB (writeRegister1_WB),
    .writeData1_WB     (writeData1_WB),
    .do_writeback1_WB  (do_writeback1_WB),
    .STALL             (STALL),
    .Instr_OUT_PR      (Instr_OUT_PR),
    .aluResult1_PR     (aluResult1_PR),
    .readDataB1_PR     (readDataB1_PR),
    .writeRegister1_PR (writeRegister1_PR),
    .do_writeback1_PR  (do_writeback1_PR),
    .MemRead1_PR       (MemRead1_PR),
    .MemWrite1_PR      (MemWrite1_PR),
    .MemtoReg1_PR      (MemtoReg1_PR),
    .md_busy           (md_busy)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] id;
    logic        chk_data;
    logic [31:0] instr;
    logic [31:0] res;
    logic [31:0] rdb;
    logic [4:0]  wreg;
    logic        wb, mr, mw, m2r;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (RESET && exp_q.size() > 0) begin
        exp_t e;
        e = exp_t'(exp_q.pop_front());
        check($sformatf("id%0d instr", e.id), Instr_OUT_PR, e.instr);
        check($sformatf("id%0d ctl", e.id),
              {28'd0, do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR},
              {28'd0, e.wb, e.mr, e.mw, e.m2r});
        if (e.chk_data) begin
          check($sformatf("id%0d result", e.id), aluResult1_PR, e.res);
          check($sformatf("id%0d store_data", e.id), readDataB1_PR, e.rdb);
          check($sformatf("id%0d wreg", e.id), {27'd0, writeRegister1_PR}, {27'd0, e.wreg});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_bubble(input int id);
    exp_t e;
    e = '0;
    e.id = 16'(id);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int id);
    @(negedge CLK);
    valid1 = 1'b0;
    #1;
    push_bubble(id);
  endtask

  task automatic send(input int id, input logic [31:0] instr, input logic [5:0] code,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] rdb,
                      input logic [4:0] wreg, input logic wb, input logic mr,
                      input logic mw, input logic m2r, input logic [31:0] exp_res,
                      input logic exp_wb, input logic chk, input int exp_stalls);
    int   n;
    exp_t e;
    n = 0;
    @(negedge CLK);
    valid1 = 1'b1;         Instr1 = instr;     ALU_control1 = code;
    operandA1 = a;         operandB1 = b;      readDataB1 = rdb;
    writeRegister1 = wreg; do_writeback1 = wb; MemRead1 = mr;
    MemWrite1 = mw;        MemtoReg1 = m2r;
    #1;
    while (STALL === 1'b1 && n < 40) begin
      push_bubble(id);
      n++;
      @(negedge CLK);
      #1;
    end
    check($sformatf("id%0d stall_cycles", id), n, exp_stalls);
    e.id = 16'(id);  e.chk_data = chk; e.instr = instr; e.res = exp_res;
    e.rdb = rdb;     e.wreg = wreg;    e.wb = exp_wb;   e.mr = mr;
    e.mw = mw;       e.m2r = m2r;
    exp_q.push_back(e);
  endtask

  task automatic alu(input int id, input logic [5:0] code, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] shamt, input logic [31:0] exp_res);
    send(id, {6'd0, 5'd1, 5'd2, 5'd3, shamt, code}, code, a, b, 32'h0, 5'd3,
         1'b1, 1'b0, 1'b0, 1'b0, exp_res, 1'b1, 1'b1, 0);
  endtask

  // Multiply/divide issue: do_writeback1 driven high to see it forced low.
  task automatic md(input int id, input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    send(id, {6'd0, 5'd1, 5'd2, 10'd0, code}, code, a, b, 32'h0, 5'd0,
         1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 0);
  endtask

  task automatic mf(input int id, input logic [5:0] code, input int stalls, input logic [31:0] exp_res);
    send(id, {16'd0, 5'd4, 5'd0, code}, code, 32'h0, 32'h0, 32'h0, 5'd4,
         1'b1, 1'b0, 1'b0, 1'b0, exp_res, 1'b1, 1'b1, stalls);
  endtask

  task automatic mt(input int id, input logic [5:0] code, input logic [31:0] a);
    send(id, {6'd0, 5'd1, 15'd0, code}, code, a, 32'h0, 32'h0, 5'd0,
         1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 0);
  endtask

  task automatic check_pr_zero(input string tag);
    check({tag, " md_busy"}, {31'd0, md_busy}, 32'd0);
    check({tag, " instr_pr"}, Instr_OUT_PR, 32'd0);
    check({tag, " result_pr"}, aluResult1_PR, 32'd0);
    check({tag, " store_pr"}, readDataB1_PR, 32'd0);
    check({tag, " wreg_pr"}, {27'd0, writeRegister1_PR}, 32'd0);
    check({tag, " ctl_pr"},
          {28'd0, do_writeback1_PR, MemRead1_PR, MemWrite1_PR, MemtoReg1_PR}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] byp_exp;
    #12;
    check_pr_zero("reset");
    check("reset stall", {31'd0, STALL}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    send(1, 32'h8D28_0000, 6'b101101, 32'h1000, 32'h3, 32'h0, 5'd8,
         1'b1, 1'b1, 1'b0, 1'b1, 32'h1003, 1'b1, 1'b1, 0);
    alu(2,  ALU_SLT,  32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1);
    alu(3,  ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0);
    alu(4,  ALU_SUB,  32'd10, 32'd3, 5'd0, 32'd7);
    alu(5,  ALU_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h00F0_000F);
    alu(6,  ALU_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFFF0_0FFF);
    alu(7,  ALU_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'hFF00_0FF0);
    alu(8,  ALU_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0, 32'h000F_F000);
    alu(9,  ALU_SLL,  32'h0, 32'h1, 5'd4, 32'h10);
    alu(10, ALU_SRL,  32'h0, 32'h8000_0000, 5'd31, 32'h1);
    alu(11, 6'b100000, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'h1);

    md(12, ALU_MULT, 32'hFFFF_FFFD, 32'd7);
    mf(13, ALU_MFLO, 32, 32'hFFFF_FFEB);
    mf(14, ALU_MFHI, 0, 32'hFFFF_FFFF);
    md(15, ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mf(16, ALU_MFHI, 32, 32'hFFFF_FFFE);
    mf(17, ALU_MFLO, 0, 32'h0000_0001);

    md(18, ALU_DIVU, 32'd100, 32'd0);
    mf(19, ALU_MFLO, 32, 32'hFFFF_FFFF);
    mf(20, ALU_MFHI, 0, 32'd100);
    md(21, ALU_DIV, 32'hFFFF_FFF9, 32'd2);
    mf(22, ALU_MFLO, 32, 32'hFFFF_FFFD);
    mf(23, ALU_MFHI, 0, 32'hFFFF_FFFF);
    md(24, ALU_DIVU, 32'd100, 32'd7);
    mf(25, ALU_MFLO, 32, 32'd14);
    mf(26, ALU_MFHI, 0, 32'd2);

    mt(27, ALU_MTHI, 32'h1234);
    mt(28, ALU_MTLO, 32'h5678);
    mf(29, ALU_MFHI, 0, 32'h1234);
    mf(30, ALU_MFLO, 0, 32'h5678);

    // Independent ADD and SW flow past an in-flight divide.
    md(31, ALU_DIV, 32'd50, 32'd5);
    alu(32, 6'b100000, 32'd1, 32'd2, 5'd0, 32'd3);
    send(33, 32'hAC22_0008, 6'b100000, 32'h100, 32'h8, 32'h0000_DEAD, 5'd0,
         1'b0, 1'b0, 1'b1, 1'b0, 32'h108, 1'b0, 1'b1, 0);
    mf(34, ALU_MFLO, 30, 32'd10);
    mf(35, ALU_MFHI, 0, 32'd0);
    idle(36);

    // Reset in the middle of a multiply.
    md(40, ALU_MULT, 32'd5, 32'd6);
    for (int i = 0; i < 9; i++) alu(41 + i, 6'b100000, i, 32'd1, 5'd0, i + 1);
    @(negedge CLK);
    valid1 = 1'b0;
    RESET = 1'b0;
    #1;
    check_pr_zero("midreset");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    mf(50, ALU_MFHI, 0, 32'd0);
    mf(51, ALU_MFLO, 0, 32'd0);

    // WB bypass: r5 written with 0xAB while the instruction reads rs=r5.
`ifdef EXE_WB_BYPASS_EN
    byp_exp = 32'hAC;
`else
    byp_exp = 32'h12;
`endif
    do_writeback1_WB  = 1'b1;
    writeRegister1_WB = 5'd5;
    writeData1_WB     = 32'hAB;
    send(60, 32'h20A0_0000, 6'b100000, 32'h11, 32'h1, 32'h0, 5'd7,
         1'b1, 1'b0, 1'b0, 1'b0, byp_exp, 1'b1, 1'b1, 0);
    @(posedge CLK);
    #2;
    do_writeback1_WB = 1'b0;

    for (int i = 0; i < 3; i++) idle(70 + i);
    @(posedge CLK);
    #2;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
